// File: rtl/gpio_debounce.sv
// gpio_debounce: per-pin input debouncer and edge detector for the GPIO block.
// Raw pins are double-flopped and then filtered. A new level is accepted only
// after it differs from the current output on thr consecutive sample strobes.
// Accepted edges set sticky rise/fall flags.
// Define GPIO_DEBOUNCE_IRQ_EN to build the masked, registered irq output.
// Without it, irq is held low, irq_mask is ignored, and the flags stay
// available for polling.
module gpio_debounce #(
  parameter int width     = 8,
  parameter int cnt_width = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_clk,
  input  logic [width-1:0]     pins_in,
  input  logic [cnt_width-1:0] stable_count,
  input  logic [width-1:0]     flag_clr,
  input  logic [width-1:0]     irq_mask,
  output logic [width-1:0]     pins_out,
  output logic [width-1:0]     rise_flag,
  output logic [width-1:0]     fall_flag,
  output logic                 irq
);

  localparam logic [cnt_width:0] WideOne = {{cnt_width{1'b0}}, 1'b1};

  logic [width-1:0]     syncMeta_q;
  logic [width-1:0]     sync_q;
  logic                 div_q;
  logic [cnt_width-1:0] cnt_q [width];
  logic [cnt_width-1:0] cnt_d [width];
  logic [cnt_width:0]   cntInc [width];
  logic [width-1:0]     pins_q, pins_d;
  logic [width-1:0]     rise_q, rise_d;
  logic [width-1:0]     fall_q, fall_d;
  logic [width-1:0]     riseSet, fallSet;
  logic                 irq_q, irq_d;
  logic                 tick;
  logic [cnt_width:0]   thr;

  // The strobe is the rising edge of div_clk, seen one clk before div_q catches up.
  assign tick = div_clk & ~div_q;

  // A programmed count of zero still needs one differing strobe; compare one bit wider so cnt+1 never wraps.
  assign thr = (stable_count == '0) ? WideOne : {1'b0, stable_count};

  // Per-pin filter: count strobes that disagree with the output, accept at threshold, and build the flag updates.
  always_comb begin
    pins_d  = pins_q;
    riseSet = '0;
    fallSet = '0;
    for (int i = 0; i < width; i++) begin
      cntInc[i] = {1'b0, cnt_q[i]} + WideOne;
      cnt_d[i]  = cnt_q[i];
      if (tick) begin
        if (sync_q[i] == pins_q[i]) begin
          cnt_d[i] = '0;
        end else if (cntInc[i] >= thr) begin
          pins_d[i] = sync_q[i];
          cnt_d[i]  = '0;
          if (sync_q[i]) begin
            riseSet[i] = 1'b1;
          end else begin
            fallSet[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = cntInc[i][cnt_width-1:0];
        end
      end
    end
    rise_d = (rise_q & ~flag_clr) | riseSet;
    fall_d = (fall_q & ~flag_clr) | fallSet;
  end

`ifdef GPIO_DEBOUNCE_IRQ_EN
  // Interrupt follows the current flag registers, so it lags a flag set or clear by one clk.
  assign irq_d = |((rise_q | fall_q) & irq_mask);
`else
  // Polled-only build: the mask input is left unused and irq never rises.
  logic unused_irq_mask;
  assign unused_irq_mask = ^irq_mask;
  assign irq_d           = 1'b0;
`endif

  // Synchroniser, strobe history, filter counters, outputs and flags; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncMeta_q <= '0;
      sync_q     <= '0;
      div_q      <= 1'b0;
      pins_q     <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      syncMeta_q <= pins_in;
      sync_q     <= syncMeta_q;
      div_q      <= div_clk;
      pins_q     <= pins_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      irq_q      <= irq_d;
      for (int i = 0; i < width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pins_out  = pins_q;
  assign rise_flag = rise_q;
  assign fall_flag = fall_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: directed scenarios followed by a randomized run. Every
// clock is compared against a behavioural model of the debouncer.
module tb_gpio_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       div_clk;
  logic [7:0] pins_in;
  logic [3:0] stable_count;
  logic [7:0] flag_clr;
  logic [7:0] irq_mask;
  logic [7:0] pins_out;
  logic [7:0] rise_flag;
  logic [7:0] fall_flag;
  logic       irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] pipeQ[$];
  int         runLen[8];
  logic       mDivPrev;
  logic [7:0] mOut, mRise, mFall;
  logic       mIrq;

`ifdef GPIO_DEBOUNCE_IRQ_EN
  localparam logic IrqBuilt = 1'b1;
`else
  localparam logic IrqBuilt = 1'b0;
`endif

  gpio_debounce #(.width(8), .cnt_width(4)) dut (
    .clk(clk), .rst(rst), .div_clk(div_clk), .pins_in(pins_in),
    .stable_count(stable_count), .flag_clr(flag_clr), .irq_mask(irq_mask),
    .pins_out(pins_out), .rise_flag(rise_flag), .fall_flag(fall_flag), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%02h expected=%02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    pipeQ = {8'h00, 8'h00};
    for (int i = 0; i < 8; i++) runLen[i] = 0;
    mDivPrev = 1'b0;
    mOut = '0; mRise = '0; mFall = '0; mIrq = 1'b0;
  endtask

  // Advance the model by one clk edge using the inputs currently applied
  task automatic modelEdge();
    logic [7:0] seen, setR, setF;
    logic       nextIrq;
    int         need;
    if (rst) begin
      modelReset();
      return;
    end
    seen    = pipeQ[0];
    nextIrq = |((mRise | mFall) & irq_mask);
    setR = '0; setF = '0;
    need = (stable_count == 0) ? 1 : int'(stable_count);
    if (div_clk && !mDivPrev) begin
      for (int i = 0; i < 8; i++) begin
        if (seen[i] == mOut[i]) runLen[i] = 0;
        else if (runLen[i] + 1 >= need) begin
          mOut[i] = seen[i];
          runLen[i] = 0;
          if (seen[i]) setR[i] = 1'b1; else setF[i] = 1'b1;
        end else runLen[i] = runLen[i] + 1;
      end
    end
    mRise = (mRise & ~flag_clr) | setR;
    mFall = (mFall & ~flag_clr) | setF;
    mIrq  = IrqBuilt & nextIrq;
    pipeQ.push_back(pins_in);
    void'(pipeQ.pop_front());
    mDivPrev = div_clk;
  endtask

  // One clk: update the model, take the edge, then compare on the falling edge
  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      modelEdge();
      @(posedge clk);
      @(negedge clk);
      checkOutput("pins_out", pins_out, mOut);
      checkOutput("rise_flag", rise_flag, mRise);
      checkOutput("fall_flag", fall_flag, mFall);
      checkOutput("irq", {7'd0, irq}, {7'd0, mIrq});
    end
  endtask

  // n sample strobes, each 2 clk high and 2 clk low
  task automatic strobe(input int n);
    for (int s = 0; s < n; s++) begin
      div_clk = 1'b1; applyStimulus(2);
      div_clk = 1'b0; applyStimulus(2);
    end
  endtask

  // Change the pins and let the synchroniser settle without any strobe
  task automatic setPins(input logic [7:0] v);
    pins_in = v;
    applyStimulus(2);
  endtask

  task automatic clearFlags(input logic [7:0] m);
    flag_clr = m; applyStimulus(1);
    flag_clr = '0; applyStimulus(1);
  endtask

  initial begin
    int k;
    @(negedge clk);
    modelReset();
    rst = 1'b1; div_clk = 1'b0; pins_in = 8'hFF; stable_count = 4'd3;
    flag_clr = '0; irq_mask = 8'h01;

    // Reset with the divider running: everything held at zero
    for (int r = 0; r < 6; r++) begin
      div_clk = ~div_clk;
      applyStimulus(1);
    end
    checkOutput("reset_pins", pins_out, 8'h00);
    checkOutput("reset_rise", rise_flag, 8'h00);
    checkOutput("reset_irq", {7'd0, irq}, 8'h00);

    // Release with stable_count=3: pins accepted on the third strobe
    div_clk = 1'b0; rst = 1'b0;
    applyStimulus(2);
    strobe(2);
    checkOutput("rel_two_ticks", pins_out, 8'h00);
    strobe(1);
    checkOutput("rel_third_tick", pins_out, 8'hFF);
    checkOutput("rel_rise", rise_flag, 8'hFF);

    // Bring all pins low and clear flags
    setPins(8'h00); strobe(3);
    checkOutput("all_low", pins_out, 8'h00);
    clearFlags(8'hFF);

    // Glitch rejection at threshold 4
    stable_count = 4'd4;
    setPins(8'h01); strobe(3);
    setPins(8'h00); strobe(1);
    checkOutput("glitch_pin", pins_out, 8'h00);
    checkOutput("glitch_rise", rise_flag, 8'h00);
    setPins(8'h01); strobe(3);
    checkOutput("held_three", pins_out, 8'h00);
    strobe(1);
    checkOutput("held_four", pins_out, 8'h01);
    checkOutput("held_four_rise", rise_flag, 8'h01);

    // Zero threshold behaves as one strobe
    stable_count = 4'd0;
    setPins(8'h05); strobe(1);
    clearFlags(8'hFF);
    setPins(8'h01); strobe(1);
    checkOutput("zero_thr_pin", pins_out, 8'h01);
    checkOutput("zero_thr_fall", fall_flag, 8'h04);

    // Set/clear collision on pin 1: set wins, later clear takes effect
    clearFlags(8'hFF);
    setPins(8'h03);
    div_clk = 1'b1; flag_clr = 8'h02; applyStimulus(1);
    flag_clr = 8'h00; applyStimulus(1);
    checkOutput("collide_set", rise_flag, 8'h02);
    div_clk = 1'b0; flag_clr = 8'h02; applyStimulus(1);
    flag_clr = 8'h00; applyStimulus(1);
    checkOutput("collide_clr", rise_flag, 8'h00);

    // Interrupt masking: only pin 0 is enabled
    irq_mask = 8'h01;
    setPins(8'h0B); strobe(1);
    clearFlags(8'hFF); applyStimulus(1);
    setPins(8'h03); strobe(1);
    checkOutput("irq_pin3_fall", {7'd0, irq}, 8'h00);
    setPins(8'h02); strobe(1);
    clearFlags(8'hFF); applyStimulus(1);
    checkOutput("irq_cleared", {7'd0, irq}, 8'h00);
    setPins(8'h03); strobe(1);
    checkOutput("irq_pin0_rise", {7'd0, irq}, {7'd0, IrqBuilt});
    flag_clr = 8'h01; applyStimulus(1);
    flag_clr = 8'h00; applyStimulus(1);
    checkOutput("irq_after_clr", {7'd0, irq}, 8'h00);

    // Reset mid-count: the partial count is lost
    stable_count = 4'd5;
    setPins(8'hFF); strobe(3);
    rst = 1'b1; applyStimulus(2);
    rst = 1'b0; applyStimulus(2);
    strobe(4);
    checkOutput("midrst_four", pins_out, 8'h00);
    strobe(1);
    checkOutput("midrst_five", pins_out, 8'hFF);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, 7);
        pins_in[k] = ~pins_in[k];
      end
      if ($urandom_range(0, 2) == 0) div_clk = ~div_clk;
      if ($urandom_range(0, 99) == 0) stable_count = 4'($urandom_range(0, 5));
      flag_clr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 49) == 0) irq_mask = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
